// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundles the hazard-detection inputs and the pipeline sequencing outputs of
// pipe_hazard_ctrl.
//
// Modports:
//   master - pipeline side: drives register fields / control bits / mem_busy,
//            receives the enables, flush/bubble controls and status.
//   slave  - the hazard controller itself.
//
// Signals (direction as seen by the controller):
//   if_id_rs, if_id_rt       in   rs/rt fields of the IF/ID instruction
//   id_ex_rd                 in   destination register in ID/EX
//   id_ex_mem_read           in   ID/EX instruction is a load
//   id_ex_reg_write          in   ID/EX instruction writes the register file
//   ex_mem_rd                in   destination register in EX/MEM
//   ex_mem_reg_write         in   EX/MEM instruction writes the register file
//   branch_taken             in   taken branch resolved in EX/MEM
//   mem_busy                 in   data memory not ready this cycle
//   pc_write                 out  PC load enable
//   if_id_write              out  IF/ID load enable
//   if_id_flush              out  IF/ID loads a NOP
//   id_ex_bubble             out  ID/EX control fields forced to 0
//   ex_mem_flush             out  EX/MEM control fields forced to 0
//   pc_sel_branch            out  PC mux selects the branch target
//   pipe_freeze              out  all pipeline registers hold
//   stall_count [CNT_W]      out  saturating count of non-advancing cycles
//   timeout_err              out  sticky memory-wait watchdog error
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             id_ex_reg_write;
    logic [4:0]       ex_mem_rd;
    logic             ex_mem_reg_write;
    logic             branch_taken;
    logic             mem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_flush;
    logic             pc_sel_branch;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_err;

    modport master (
        output if_id_rs,
        output if_id_rt,
        output id_ex_rd,
        output id_ex_mem_read,
        output id_ex_reg_write,
        output ex_mem_rd,
        output ex_mem_reg_write,
        output branch_taken,
        output mem_busy,
        input  pc_write,
        input  if_id_write,
        input  if_id_flush,
        input  id_ex_bubble,
        input  ex_mem_flush,
        input  pc_sel_branch,
        input  pipe_freeze,
        input  stall_count,
        input  timeout_err
    );

    modport slave (
        input  if_id_rs,
        input  if_id_rt,
        input  id_ex_rd,
        input  id_ex_mem_read,
        input  id_ex_reg_write,
        input  ex_mem_rd,
        input  ex_mem_reg_write,
        input  branch_taken,
        input  mem_busy,
        output pc_write,
        output if_id_write,
        output if_id_flush,
        output id_ex_bubble,
        output ex_mem_flush,
        output pc_sel_branch,
        output pipe_freeze,
        output stall_count,
        output timeout_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for a 5-stage MIPS pipeline. Handles load-use
// stalls, taken-branch flushes (branch resolved in MEM) and multi-cycle data
// memory waits guarded by a timeout watchdog. Control outputs are combinational
// from the FSM state and the current inputs so they act in the cycle the
// condition is seen.
//
// Configuration macro:
//   FORWARDING_EN - defined: only load-use hazards stall (forwarding covers the
//                   rest). Undefined: any RAW hazard against ID/EX or EX/MEM
//                   stalls until the producer has left those stages.
//
// Parameters:
//   WAIT_TIMEOUT - consecutive mem_busy cycles before timeout_err is raised
//                  (must be >= 1)
//   CNT_W        - width of stall_count; must match the interface's CNT_W
//
// Ports:
//   i_clk  in  pipeline clock
//   i_rst  in  synchronous active-high reset
//   io_hz      pipe_hazard_ctrl_if.slave (hazard inputs, sequencing outputs)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pipe_hazard_ctrl_if.slave        io_hz
);

    // Wait counter is at least 8 bits, wider if the timeout needs it.
    localparam int unsigned WCNT_W =
        ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;
    localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(WAIT_TIMEOUT);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_timeout_err;
    logic              w_timeout_nxt;

    logic              w_pc_write;
    logic              w_if_id_write;
    logic              w_if_id_flush;
    logic              w_id_ex_bubble;
    logic              w_ex_mem_flush;
    logic              w_pc_sel_branch;
    logic              w_pipe_freeze;

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    logic w_id_ex_match;
    logic w_ex_mem_match;
    logic w_load_use;
    logic w_stall;

    // $zero is never a real producer, so rd==0 never matches.
    assign w_id_ex_match = (io_hz.id_ex_rd != 5'd0) &&
                           ((io_hz.id_ex_rd == io_hz.if_id_rs) ||
                            (io_hz.id_ex_rd == io_hz.if_id_rt));
    assign w_ex_mem_match = (io_hz.ex_mem_rd != 5'd0) &&
                            ((io_hz.ex_mem_rd == io_hz.if_id_rs) ||
                             (io_hz.ex_mem_rd == io_hz.if_id_rt));
    assign w_load_use = io_hz.id_ex_mem_read && w_id_ex_match;

`ifdef FORWARDING_EN
    logic w_unused_fwd;
    assign w_stall      = w_load_use;
    assign w_unused_fwd = io_hz.id_ex_reg_write ^ io_hz.ex_mem_reg_write ^ w_ex_mem_match;
`else
    // Without forwarding every RAW dependency on an in-flight producer stalls;
    // it clears by itself once the producer has drained past EX/MEM.
    assign w_stall = w_load_use ||
                     (io_hz.id_ex_reg_write && w_id_ex_match) ||
                     (io_hz.ex_mem_reg_write && w_ex_mem_match);
`endif

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // -------------------------------------------------------------------------
    logic w_eval_run;
    logic w_enter_wait;

    always_comb begin
        // Default: normal advancing pipeline.
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_flush  = 1'b0;
        w_pc_sel_branch = 1'b0;
        w_pipe_freeze   = 1'b0;
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_eval_run      = 1'b0;
        w_enter_wait    = 1'b0;

        if (i_rst) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (io_hz.mem_busy) begin
                        // branch_taken is ignored: EX/MEM is frozen and the
                        // branch is re-seen once the wait ends.
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_pipe_freeze = 1'b1;
                        if (r_wait_cnt != TIMEOUT_VAL) begin
                            w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                        end
                    end else begin
                        // The exit cycle already behaves exactly like RUN.
                        w_eval_run = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // IF/ID holds a NOP and EX/MEM a bubble, so neither
                    // hazard detection nor branch_taken is meaningful here.
                    if (io_hz.mem_busy) begin
                        w_enter_wait = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_eval_run = 1'b1;
                end
            endcase

            if (w_eval_run) begin
                w_state_nxt = ST_RUN;
                if (io_hz.branch_taken) begin
                    w_pc_sel_branch = 1'b1;
                    w_if_id_flush   = 1'b1;
                    w_id_ex_bubble  = 1'b1;
                    w_ex_mem_flush  = 1'b1;
                    w_state_nxt     = ST_FLUSH;
                end else if (io_hz.mem_busy) begin
                    w_enter_wait = 1'b1;
                end else if (w_stall) begin
                    // One-cycle stall: the bubble injected into ID/EX removes
                    // the producer from the comparison next cycle.
                    w_pc_write     = 1'b0;
                    w_if_id_write  = 1'b0;
                    w_id_ex_bubble = 1'b1;
                end
            end

            if (w_enter_wait) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_pipe_freeze  = 1'b1;
                w_wait_cnt_nxt = WCNT_W'(1);
                w_state_nxt    = ST_WAIT;
            end
        end
    end

    // Raised on the edge that ends the WAIT_TIMEOUT-th consecutive busy cycle.
    assign w_timeout_nxt = r_timeout_err ||
                           (w_pipe_freeze && (w_wait_cnt_nxt == TIMEOUT_VAL));

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_timeout_err <= w_timeout_nxt;
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign io_hz.pc_write      = w_pc_write;
    assign io_hz.if_id_write   = w_if_id_write;
    assign io_hz.if_id_flush   = w_if_id_flush;
    assign io_hz.id_ex_bubble  = w_id_ex_bubble;
    assign io_hz.ex_mem_flush  = w_ex_mem_flush;
    assign io_hz.pc_sel_branch = w_pc_sel_branch;
    assign io_hz.pipe_freeze   = w_pipe_freeze;
    assign io_hz.stall_count   = r_stall_cnt;
    assign io_hz.timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios with literal expectations, followed by randomized traffic.
// A behavioural model tracks "in a memory wait", "just flushed by a branch",
// the length of the current busy run, the stall count and the sticky error,
// and is compared against every DUT output on every negative clock edge.
// Built with WAIT_TIMEOUT=4 and CNT_W=8 so timeout and saturation are reachable.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO    = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          SMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipe_hazard_ctrl #(
        .WAIT_TIMEOUT (TO),
        .CNT_W        (CNT_W)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_hz (hz_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Stall rule from the hazard definitions.
    function automatic bit model_stall();
        bit lu;
        bit idex_m;
        bit exmem_m;
        idex_m  = (hz_if.id_ex_rd != 0) &&
                  (hz_if.id_ex_rd == hz_if.if_id_rs || hz_if.id_ex_rd == hz_if.if_id_rt);
        exmem_m = (hz_if.ex_mem_rd != 0) &&
                  (hz_if.ex_mem_rd == hz_if.if_id_rs || hz_if.ex_mem_rd == hz_if.if_id_rt);
        lu = hz_if.id_ex_mem_read && idex_m;
`ifdef FORWARDING_EN
        return lu;
`else
        return lu || (hz_if.id_ex_reg_write && idex_m) || (hz_if.ex_mem_reg_write && exmem_m);
`endif
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural model + compare process
    // ---------------------------------------------------------------------
    bit m_in_wait  = 0;
    bit m_after_br = 0;
    int m_busy_run = 0;
    int m_stall    = 0;
    bit m_err      = 0;

    always @(negedge clk) begin
        bit e_pcw, e_ifw, e_iff, e_bub, e_exf, e_sel, e_frz;
        int e_cnt;
        bit e_err;
        bit freeze_now;
        e_cnt = m_stall;
        e_err = m_err;
        {e_iff, e_bub, e_exf, e_sel, e_frz} = '0;
        e_pcw = 1;
        e_ifw = 1;
        freeze_now = 0;
        if (rst) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_bub = 1; e_exf = 1;
            m_in_wait = 0; m_after_br = 0; m_busy_run = 0; m_stall = 0; m_err = 0;
        end else begin
            if (m_in_wait && hz_if.mem_busy) begin
                freeze_now = 1;
                m_busy_run++;
            end else if (m_after_br) begin
                m_after_br = 0;
                if (hz_if.mem_busy) begin
                    freeze_now = 1;
                    m_busy_run = 1;
                end
            end else begin
                m_in_wait = 0;
                if (hz_if.branch_taken) begin
                    e_sel = 1; e_iff = 1; e_bub = 1; e_exf = 1;
                    m_after_br = 1;
                end else if (hz_if.mem_busy) begin
                    freeze_now = 1;
                    m_busy_run = 1;
                end else if (model_stall()) begin
                    e_pcw = 0; e_ifw = 0; e_bub = 1;
                end
            end
            if (freeze_now) begin
                e_pcw = 0; e_ifw = 0; e_frz = 1;
                m_in_wait = 1;
                if (m_busy_run >= TO) m_err = 1;
            end else begin
                m_in_wait = 0;
            end
            if (!e_pcw && m_stall < SMAX) m_stall++;
        end
        check("pc_write",      int'(hz_if.pc_write),      int'(e_pcw));
        check("if_id_write",   int'(hz_if.if_id_write),   int'(e_ifw));
        check("if_id_flush",   int'(hz_if.if_id_flush),   int'(e_iff));
        check("id_ex_bubble",  int'(hz_if.id_ex_bubble),  int'(e_bub));
        check("ex_mem_flush",  int'(hz_if.ex_mem_flush),  int'(e_exf));
        check("pc_sel_branch", int'(hz_if.pc_sel_branch), int'(e_sel));
        check("pipe_freeze",   int'(hz_if.pipe_freeze),   int'(e_frz));
        check("stall_count",   int'(hz_if.stall_count),   e_cnt);
        check("timeout_err",   int'(hz_if.timeout_err),   int'(e_err));
    end

    // ---------------------------------------------------------------------
    // Stimulus with literal expectations
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.if_id_rs         = 5'd0;
        hz_if.if_id_rt         = 5'd0;
        hz_if.id_ex_rd         = 5'd0;
        hz_if.id_ex_mem_read   = 1'b0;
        hz_if.id_ex_reg_write  = 1'b0;
        hz_if.ex_mem_rd        = 5'd0;
        hz_if.ex_mem_reg_write = 1'b0;
        hz_if.branch_taken     = 1'b0;
        hz_if.mem_busy         = 1'b0;
    endtask

    initial begin
        int burst;
        rst = 1'b1;
        clear_inputs();

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        check("rst pc_write",     int'(hz_if.pc_write),     0);
        check("rst if_id_flush",  int'(hz_if.if_id_flush),  1);
        check("rst id_ex_bubble", int'(hz_if.id_ex_bubble), 1);
        check("rst ex_mem_flush", int'(hz_if.ex_mem_flush), 1);
        check("rst stall_count",  int'(hz_if.stall_count),  0);
        check("rst timeout_err",  int'(hz_if.timeout_err),  0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("post-rst pc_write",    int'(hz_if.pc_write),    1);
        check("post-rst if_id_write", int'(hz_if.if_id_write), 1);

        // Load-use on rs.
        step();
        hz_if.id_ex_mem_read = 1'b1; hz_if.id_ex_rd = 5'd8; hz_if.if_id_rs = 5'd8;
        @(negedge clk);
        check("lu pc_write",     int'(hz_if.pc_write),     0);
        check("lu if_id_write",  int'(hz_if.if_id_write),  0);
        check("lu id_ex_bubble", int'(hz_if.id_ex_bubble), 1);
        step(); hz_if.id_ex_mem_read = 1'b0;
        @(negedge clk);
        check("lu-after pc_write",    int'(hz_if.pc_write),    1);
        check("lu-after stall_count", int'(hz_if.stall_count), 1);

        // Load to $zero never stalls.
        step(); hz_if.id_ex_mem_read = 1'b1; hz_if.id_ex_rd = 5'd0; hz_if.if_id_rs = 5'd0;
        @(negedge clk);
        check("lu-r0 pc_write", int'(hz_if.pc_write), 1);

        // Branch wins over a simultaneous load-use, then FLUSH suppresses it.
        step(); hz_if.id_ex_rd = 5'd8; hz_if.if_id_rs = 5'd8; hz_if.branch_taken = 1'b1;
        @(negedge clk);
        check("br pc_sel_branch", int'(hz_if.pc_sel_branch), 1);
        check("br if_id_flush",   int'(hz_if.if_id_flush),   1);
        check("br id_ex_bubble",  int'(hz_if.id_ex_bubble),  1);
        check("br ex_mem_flush",  int'(hz_if.ex_mem_flush),  1);
        check("br pc_write",      int'(hz_if.pc_write),      1);
        step(); hz_if.branch_taken = 1'b0;
        @(negedge clk);
        check("flush pc_write",     int'(hz_if.pc_write),     1);
        check("flush id_ex_bubble", int'(hz_if.id_ex_bubble), 0);
        step();
        @(negedge clk);
        check("run-lu pc_write", int'(hz_if.pc_write), 0);
        step(); clear_inputs();
        @(negedge clk);
        check("pre-wait stall_count", int'(hz_if.stall_count), 2);

        // Memory wait of five cycles; the watchdog fires after the fourth.
        step(); hz_if.mem_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("wait pipe_freeze", int'(hz_if.pipe_freeze), 1);
            check("wait pc_write",    int'(hz_if.pc_write),    0);
            check("wait timeout_err", int'(hz_if.timeout_err), (i == 5) ? 1 : 0);
            step();
        end
        hz_if.mem_busy = 1'b0;
        @(negedge clk);
        check("wait-exit pc_write",    int'(hz_if.pc_write),    1);
        check("wait-exit pipe_freeze", int'(hz_if.pipe_freeze), 0);
        check("wait-exit stall_count", int'(hz_if.stall_count), 7);
        check("sticky timeout_err",    int'(hz_if.timeout_err), 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check("rst-clr timeout_err", int'(hz_if.timeout_err), 0);
        check("rst-clr stall_count", int'(hz_if.stall_count), 0);

        // EX/MEM producer feeding rt: stalls only without forwarding.
        step(); hz_if.ex_mem_reg_write = 1'b1; hz_if.ex_mem_rd = 5'd9; hz_if.if_id_rt = 5'd9;
        @(negedge clk);
`ifdef FORWARDING_EN
        check("exmem-raw pc_write", int'(hz_if.pc_write), 1);
`else
        check("exmem-raw pc_write", int'(hz_if.pc_write), 0);
`endif
        step(); clear_inputs();
        @(negedge clk);
        check("exmem-raw-after pc_write", int'(hz_if.pc_write), 1);

        // Long wait drives stall_count into saturation.
        step(); hz_if.mem_busy = 1'b1;
        repeat (300) step();
        @(negedge clk);
        check("sat stall_count", int'(hz_if.stall_count), SMAX);
        check("sat timeout_err", int'(hz_if.timeout_err), 1);
        step(); hz_if.mem_busy = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;

        // Randomized traffic; the compare process does the checking.
        burst = 0;
        repeat (4000) begin
            step();
            rst = ($urandom_range(0, 599) == 0);
            hz_if.if_id_rs         = 5'($urandom_range(0, 3));
            hz_if.if_id_rt         = 5'($urandom_range(0, 3));
            hz_if.id_ex_rd         = 5'($urandom_range(0, 3));
            hz_if.ex_mem_rd        = 5'($urandom_range(0, 3));
            hz_if.id_ex_mem_read   = 1'($urandom_range(0, 1));
            hz_if.id_ex_reg_write  = 1'($urandom_range(0, 1));
            hz_if.ex_mem_reg_write = 1'($urandom_range(0, 1));
            hz_if.branch_taken     = ($urandom_range(0, 7) == 0);
            if (burst > 0) begin
                hz_if.mem_busy = 1'b1;
                burst--;
            end else begin
                hz_if.mem_busy = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(2, 8);
            end
        end
        step();
        clear_inputs();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Inputs: register fields and control bits from the IF/ID, ID/EX and EX/MEM pipeline registers, plus a memory-busy indication.
- Outputs: the write-enables and flush/bubble controls that sequence the PC and the pipeline registers.
- Handles load-use stalls, taken-branch flushes (branch resolved in MEM) and multi-cycle memory waits with a timeout watchdog.

Parameters:
- WAIT_TIMEOUT, 255: max consecutive mem_busy cycles before timeout_err is raised.
- CNT_W, 16: width of the stall_count performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- if_id_rs  in  5  rs field of the instruction in IF/ID.
- if_id_rt  in  5  rt field of the instruction in IF/ID.
- id_ex_rd  in  5  destination register of the instruction in ID/EX.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- id_ex_reg_write  in  1  ID/EX instruction writes the register file.
- ex_mem_rd  in  5  destination register in EX/MEM.
- ex_mem_reg_write  in  1  EX/MEM instruction writes the register file.
- branch_taken  in  1  EX/MEM branch with ex_mem_zero=1 (taken).
- mem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID load with NOP.
- id_ex_bubble  out  1  ID/EX control fields forced to 0.
- ex_mem_flush  out  1  EX/MEM control fields forced to 0.
- pc_sel_branch  out  1  PC mux selects the branch target (ex_mem_pc_4_off).
- pipe_freeze  out  1  all pipeline registers hold (memory wait).
- stall_count  out  CNT_W  saturating count of non-advancing cycles.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- One clock domain (clk); synchronous active-high reset (rst). All state changes on posedge clk.
- Registered state: 2-bit FSM (RUN, FLUSH, WAIT), wait counter (8 bits min, sized to WAIT_TIMEOUT), stall_count, timeout_err.
- Control outputs are combinational from FSM state and current inputs, so they act in the same cycle the condition is seen.
- While rst=1:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_sel_branch=0, pipe_freeze=0.
  - Next state RUN; counters=0; timeout_err=0.
  - Reset mid-WAIT or mid-FLUSH aborts to RUN.
- Load-use hazard (lu): id_ex_mem_read & id_ex_rd!=0 & (id_ex_rd==if_id_rs | id_ex_rd==if_id_rt).
- Priority in RUN: branch_taken > mem_busy > lu > normal.
- RUN, branch_taken=1:
  - pc_write=1, pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
  - Next state FLUSH.
- RUN, mem_busy=1 (no branch):
  - pipe_freeze=1, pc_write=0, if_id_write=0.
  - Wait counter loads 1; next state WAIT.
- RUN, lu=1:
  - pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle.
  - Stay in RUN. The stall resolves next cycle because ID/EX then holds a bubble.
- RUN, normal: pc_write=1, if_id_write=1, all flush/bubble=0.
- FLUSH: lasts one cycle.
  - Outputs as normal, except hazard detection is suppressed (IF/ID holds a NOP).
  - mem_busy in FLUSH -> WAIT, same as in RUN. Else -> RUN.
- WAIT:
  - pipe_freeze=1, pc_write=0, if_id_write=0; wait counter +1 per cycle.
  - mem_busy=0 -> RUN. Outputs that cycle are already normal RUN outputs.
  - branch_taken is ignored until WAIT exits; EX/MEM is frozen, so it is re-seen in RUN.
  - Wait counter reaching WAIT_TIMEOUT: timeout_err<=1 (sticky until rst), FSM stays in WAIT.
- stall_count:
  - +1 on every cycle with pc_write=0 while rst=0.
  - Saturates at all-ones; no wrap.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: only the load-use hazard above stalls; the forwarding unit covers other RAW hazards.
- Undefined: the stall condition extends to any RAW hazard against ID/EX (id_ex_reg_write & id_ex_rd!=0 & match rs/rt) or EX/MEM (ex_mem_reg_write & ex_mem_rd!=0 & match rs/rt).
  - Same per-cycle stall outputs as lu.
  - Repeats each cycle until no match remains (up to 2 cycles).

Test Plan:
- Reset: rst=1 for 2 cycles -> pc_write=0, all flush=1, stall_count=0, timeout_err=0; first cycle after release -> pc_write=1, if_id_write=1.
- Load-use: id_ex_mem_read=1, id_ex_rd=8, if_id_rs=8 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1, stall_count=1; then id_ex_mem_read=0 -> normal. Same with id_ex_rd=0 -> no stall.
- Branch: branch_taken=1 together with lu=1 -> pc_sel_branch=1, three flushes, no stall; next cycle FLUSH with lu inputs still matching -> no stall.
- Memory wait: mem_busy=1 for 5 cycles -> pipe_freeze=1 for 5 cycles, stall_count=5; the cycle mem_busy=0 -> pc_write=1.
- Timeout: WAIT_TIMEOUT=4, mem_busy held 10 cycles -> timeout_err=1 after the 4th wait cycle, stays 1 after mem_busy drops; rst clears it.
- FORWARDING_EN undefined: ex_mem_reg_write=1, ex_mem_rd=9, if_id_rt=9 -> 1-cycle stall. Defined: no stall.
